// File: rtl/fetch_stage2.sv
// Fetch stage 2: aligns synchronous SRAM read data with the PC from fetch stage 1 and
// holds the instruction across stalls. Define FETCH2_MISALIGN_EXCP_EN to flag misaligned PCs.
`ifndef StallBus
`define StallBus 1:0
`endif

module fetch_stage2 #(
    parameter int IF12IF2_WD = 50,
    parameter int IF22ID_WD  = 66
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [`StallBus]      stall,
    input  logic [32:0]           br_bus,
    input  logic [IF12IF2_WD-1:0] if12if2_bus,
    input  logic [63:0]           inst_sram_rdata,
    output logic [IF22ID_WD-1:0]  if22id_bus
);

    logic        br_e;
    logic        kill;
    logic        valid_r;
    logic [31:0] pc_r;
    logic        buf_valid;
    logic [31:0] inst_buf;
    logic [31:0] sel;
    logic [31:0] inst;
    logic        excp;
    logic        unused_bits;

    assign br_e        = br_bus[32];
    assign kill        = flush | br_e;
    assign unused_bits = ^{if12if2_bus[IF12IF2_WD-1:33], br_bus[31:0]};

    assign sel = pc_r[2] ? inst_sram_rdata[63:32] : inst_sram_rdata[31:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
        end else if (kill) begin
            valid_r <= 1'b0;
        end else if (stall[0] && !stall[1]) begin
            valid_r <= 1'b0;
        end else if (!stall[0]) begin
            valid_r <= if12if2_bus[32];
            pc_r    <= if12if2_bus[31:0];
        end
    end

    // The SRAM only presents data for one cycle, so the word is latched on the first
    // stalled edge and kept until the stall drops or the stage is killed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            inst_buf  <= '0;
        end else if (kill || !stall[1]) begin
            buf_valid <= 1'b0;
        end else if (valid_r && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= sel;
        end
    end

`ifdef FETCH2_MISALIGN_EXCP_EN
    assign excp = valid_r & (pc_r[1:0] != 2'b00);
`else
    assign excp = 1'b0;
`endif

    always_comb begin
        inst = '0;
        if (valid_r) begin
            inst = buf_valid ? inst_buf : sel;
            if (excp) begin
                inst = 32'h0000_0013;
            end
        end
    end

    assign if22id_bus = {excp, valid_r, pc_r, inst};

endmodule

// File: doc/fetch_stage2.md
FETCH_STAGE2 -- requirements
Module: fetch_stage2

Interface
REQ-001 Parameter IF12IF2_WD, 50, width of the incoming bus from fetch stage 1; only bits [32:0] = {pc_valid, pc} are used.
REQ-002 Parameter IF22ID_WD, 66, width of the outgoing bus to decode: {excp, valid, pc[31:0], inst[31:0]}.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  pipeline flush; kills stage contents.
REQ-006 stall  input  `StallBus  stall vector; stall[0] = fetch stage 1 held, stall[1] = this stage held.
REQ-007 br_bus  input  33  {br_e, br_addr}; only br_e is used (wrong-path kill).
REQ-008 if12if2_bus  input  IF12IF2_WD  {pc_valid, pc} from fetch stage 1.
REQ-009 inst_sram_rdata  input  64  synchronous SRAM read data, valid the cycle after the request.
REQ-010 if22id_bus  output  IF22ID_WD  {excp, valid, pc, inst} to decode.

Function
REQ-011 Stage registers valid_r (1b) and pc_r (32b) SHALL update each posedge by priority: flush -> valid_r=0; br_e -> valid_r=0; stall[0] & !stall[1] -> valid_r=0 (bubble), pc_r unchanged; !stall[0] -> {valid_r, pc_r} = if12if2_bus[32:0]; otherwise hold.
REQ-012 Word select: sel = pc_r[2] ? rdata[63:32] : rdata[31:0].
REQ-013 Hold buffer: inst_buf (32b) plus buf_valid (1b); when stall[1] & valid_r & !buf_valid & !flush & !br_e, SHALL capture sel and set buf_valid at that edge.
REQ-014 buf_valid SHALL clear at any edge where flush, br_e, or !stall[1] holds; inst_buf value is don't-care when buf_valid=0.
REQ-015 While buf_valid=1, inst_buf SHALL NOT be overwritten, whatever rdata does.
REQ-016 Output inst = !valid_r ? 0 : (buf_valid ? inst_buf : sel); purely combinational from registers and rdata.
REQ-017 Output valid = valid_r; output pc = pc_r, including while invalid.
REQ-018 Latency: pc accepted at edge N appears on if22id_bus with its instruction during cycle N..N+1, zero extra cycles when unstalled.
REQ-019 Simultaneous flush and br_e: flush rule applies; the result is identical (stage empty, buffer cleared).
REQ-020 Stall held for k cycles: output SHALL be constant (same pc, same inst) for all k cycles and the first cycle after release.

Reset
REQ-021 With rst_n=0 at an edge: valid_r=0, pc_r=0, buf_valid=0, inst_buf=0; if22id_bus SHALL read all zeros the cycle after.
REQ-022 Reset SHALL override flush, br_e and stall; reset during an active stall discards the buffered instruction.

Configuration
REQ-023 Macro FETCH2_MISALIGN_EXCP_EN defined: excp = valid_r & (pc_r[1:0] != 0); when excp=1, inst SHALL be 32'h0000_0013 (nop), and the buffer SHALL still operate.
REQ-024 Macro undefined: excp SHALL be constant 0; inst follows REQ-016 regardless of pc_r[1:0].

Verification
REQ-025 Unstalled stream: pc 0x8000_0000, 0x8000_0004, rdata 0x1111_1111_2222_2222 -> inst 0x2222_2222, then 0x1111_1111, valid=1 each cycle.
REQ-026 Stall[1:0]=11 for 3 cycles with pc 0x8000_0004; rdata 0xAAAA_AAAA_xxxx, then garbage -> inst stays 0xAAAA_AAAA for all 3 cycles and the release cycle.
REQ-027 br_e=1 for one cycle while stage holds valid pc 0x8000_0010 -> next cycle valid=0, inst=0, buf_valid=0.
REQ-028 flush=1 during a 2-cycle stall with buffer full -> next cycle valid=0; after release, new pc loaded and fresh rdata used (not the stale buffer).
REQ-029 stall[0]=1, stall[1]=0 -> valid=0 bubble on output next cycle; pc_r retains the previous value.
REQ-030 Macro on, pc 0x8000_0002 valid -> excp=1, inst=0x0000_0013; macro off, same stimulus -> excp=0, inst=selected rdata word.
